// File: rtl/ring_decoder.sv
// ring_decoder
// Decodes a one-hot code from a right-rotating ring counter into a binary
// index, and tracks whether the counter is rotating correctly. After LOCK_N
// consecutive correct steps the decoder locks. While locked, any stall,
// skip or malformed code raises a one-cycle err pulse and drops back to
// searching. All outputs are registered, so a sample taken on one clock
// edge shows up on the outputs right after that edge.

module ring_decoder #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 2,
    localparam int IDXW  = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  ring_in,
    output logic [IDXW-1:0]   idx,
    output logic              valid,
    output logic              locked,
    output logic              err,
    output logic              wrap,
    output logic [7:0]        err_cnt
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [3:0]        mcnt;
    logic [3:0]        mcnt_nxt;
    logic [3:0]        mcnt_inc;

    logic [IDXW-1:0]   idx_nxt;
    logic              valid_nxt;
    logic              err_nxt;
    logic              wrap_nxt;
    logic [7:0]        err_cnt_nxt;
    logic [7:0]        err_cnt_sat;

    logic [4:0]        ones;
    logic [IDXW-1:0]   code_pos;
    logic              code_legal;
    logic [IDXW-1:0]   succ;
    logic              is_succ;

    // Count the set bits of the sample and note where the (highest) one sits.
    always_comb begin
        ones     = '0;
        code_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                ones     = ones + 5'd1;
                code_pos = IDXW'(i);
            end
        end
    end

    assign code_legal = (ones == 5'd1);

    // The counter rotates right, so the next index is one lower, with 0
    // wrapping back to the top bit.
    assign succ    = (idx == '0) ? IDXW'(WIDTH - 1) : (idx - IDXW'(1));
    assign is_succ = code_legal && (code_pos == succ);

    assign mcnt_inc    = mcnt + 4'd1;
    assign err_cnt_sat = (err_cnt == 8'hFF) ? err_cnt : (err_cnt + 8'd1);

    assign locked = (state == LOCKED);

    // Next-state and next-output logic; pulses default low and everything
    // else holds, so en=0 freezes the decoder.
    always_comb begin
        state_nxt   = state;
        mcnt_nxt    = mcnt;
        idx_nxt     = idx;
        valid_nxt   = valid;
        err_nxt     = 1'b0;
        wrap_nxt    = 1'b0;
        err_cnt_nxt = err_cnt;

        if (en) begin
            case (state)
                SEARCH: begin
                    if (!code_legal) begin
                        valid_nxt = 1'b0;
                        mcnt_nxt  = '0;
                    end else begin
                        idx_nxt   = code_pos;
                        valid_nxt = 1'b1;
                        if (valid && is_succ) begin
                            if (mcnt_inc == 4'(LOCK_N)) begin
                                state_nxt = LOCKED;
                                mcnt_nxt  = '0;
                            end else begin
                                mcnt_nxt  = mcnt_inc;
                            end
                        end else begin
                            mcnt_nxt = '0;
                        end
                    end
                end

                LOCKED: begin
                    if (is_succ) begin
                        idx_nxt   = code_pos;
                        valid_nxt = 1'b1;
                        wrap_nxt  = (idx == '0);
                    end else begin
                        err_nxt     = 1'b1;
                        err_cnt_nxt = err_cnt_sat;
                        state_nxt   = SEARCH;
                        mcnt_nxt    = '0;
                        if (code_legal) begin
                            idx_nxt   = code_pos;
                            valid_nxt = 1'b1;
                        end else begin
                            valid_nxt = 1'b0;
                        end
                    end
                end

                default: begin
                    state_nxt = SEARCH;
                    mcnt_nxt  = '0;
                end
            endcase
        end
    end

    // State and output registers; reset wipes all rotation history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEARCH;
            mcnt    <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            wrap    <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            mcnt    <= mcnt_nxt;
            idx     <= idx_nxt;
            valid   <= valid_nxt;
            err     <= err_nxt;
            wrap    <= wrap_nxt;
            err_cnt <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder
// Directed bench for ring_decoder (WIDTH=4, LOCK_N=2). A behavioural model
// follows the decoder's rules sample by sample and a compare process checks
// every output against it on each falling edge; directed steps also pin
// hand-computed values.

module tb_ring_decoder;

    localparam int WIDTH  = 4;
    localparam int LOCK_N = 2;
    localparam int IDXW   = 2;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [WIDTH-1:0]  ring_in;
    logic [IDXW-1:0]   idx;
    logic              valid;
    logic              locked;
    logic              err;
    logic              wrap;
    logic [7:0]        err_cnt;

    int checks;
    int failures;
    int cur;
    int s1;
    int s2;

    typedef struct packed {
        int idx;
        bit valid;
        bit locked;
        bit err;
        bit wrap;
        int err_cnt;
        int runs;
    } model_t;

    model_t mdl;

    ring_decoder #(.WIDTH(WIDTH), .LOCK_N(LOCK_N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .ring_in (ring_in),
        .idx     (idx),
        .valid   (valid),
        .locked  (locked),
        .err     (err),
        .wrap    (wrap),
        .err_cnt (err_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after one sample, worked out from the rules: a legal
    // code has one bit set, the expected next position is one lower modulo
    // WIDTH, LOCK_N correct steps in a row lock, anything else while locked
    // is an error.
    function automatic model_t model_step(model_t m, logic en_s, logic [WIDTH-1:0] code);
        model_t n;
        int     pos;
        int     expect_next;
        bit     legal;
        n      = m;
        n.err  = 1'b0;
        n.wrap = 1'b0;
        if (!en_s) return n;
        pos = 0;
        for (int i = 0; i < WIDTH; i++) if (code[i]) pos = i;
        legal       = ($countones(code) == 1);
        expect_next = (m.idx + WIDTH - 1) % WIDTH;
        if (m.locked) begin
            if (legal && pos == expect_next) begin
                n.idx   = pos;
                n.valid = 1'b1;
                n.wrap  = (m.idx == 0);
            end else begin
                n.err     = 1'b1;
                n.err_cnt = (m.err_cnt >= 255) ? 255 : m.err_cnt + 1;
                n.locked  = 1'b0;
                n.runs    = 0;
                n.valid   = legal;
                if (legal) n.idx = pos;
            end
        end else if (!legal) begin
            n.valid = 1'b0;
            n.runs  = 0;
        end else begin
            n.runs  = (m.valid && pos == expect_next) ? m.runs + 1 : 0;
            n.idx   = pos;
            n.valid = 1'b1;
            if (n.runs >= LOCK_N) begin
                n.locked = 1'b1;
                n.runs   = 0;
            end
        end
        return n;
    endfunction

    // Model advances on the same edge the decoder samples on.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= '0;
        else        mdl <= model_step(mdl, en, ring_in);
    end

    // One comparison, counted, with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model on each falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("mdl.idx",     int'(idx),     mdl.idx);
            checkOutput("mdl.valid",   int'(valid),   int'(mdl.valid));
            checkOutput("mdl.locked",  int'(locked),  int'(mdl.locked));
            checkOutput("mdl.err",     int'(err),     int'(mdl.err));
            checkOutput("mdl.wrap",    int'(wrap),    int'(mdl.wrap));
            checkOutput("mdl.err_cnt", int'(err_cnt), mdl.err_cnt);
            checkOutput("err_wrap_excl", int'(err & wrap), 0);
        end
    end

    // Drive one sample on the falling edge, then settle just after the rising edge.
    task automatic applyStimulus(input logic e, input logic [WIDTH-1:0] code);
        @(negedge clk);
        en      = e;
        ring_in = code;
        @(posedge clk);
        #1;
    endtask

    // Pin all outputs to hand-computed values.
    task automatic checkAll(input string tag, input int e_idx, input int e_valid,
                            input int e_locked, input int e_err, input int e_wrap,
                            input int e_cnt);
        checkOutput({tag, ".idx"},     int'(idx),     e_idx);
        checkOutput({tag, ".valid"},   int'(valid),   e_valid);
        checkOutput({tag, ".locked"},  int'(locked),  e_locked);
        checkOutput({tag, ".err"},     int'(err),     e_err);
        checkOutput({tag, ".wrap"},    int'(wrap),    e_wrap);
        checkOutput({tag, ".err_cnt"}, int'(err_cnt), e_cnt);
    endtask

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        ring_in  = '0;
        repeat (3) @(negedge clk);
        checkAll("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Acquire lock from scratch.
        applyStimulus(1'b1, 4'b1000); checkAll("acq1", 3, 1, 0, 0, 0, 0);
        applyStimulus(1'b1, 4'b0100); checkAll("acq2", 2, 1, 0, 0, 0, 0);
        applyStimulus(1'b1, 4'b0010); checkAll("acq3", 1, 1, 1, 0, 0, 0);

        // Wrap from 0 to the top bit, then a hold cycle clears the pulse.
        applyStimulus(1'b1, 4'b0001); checkAll("wrap0", 0, 1, 1, 0, 0, 0);
        applyStimulus(1'b1, 4'b1000); checkAll("wrap1", 3, 1, 1, 0, 1, 0);
        applyStimulus(1'b0, 4'b1111); checkAll("wraphold", 3, 1, 1, 0, 0, 0);
        applyStimulus(1'b1, 4'b0100); checkAll("wrap2", 2, 1, 1, 0, 0, 0);

        // Skip while locked at idx 2, then relock.
        applyStimulus(1'b1, 4'b1000); checkAll("skip", 3, 1, 0, 1, 0, 1);
        applyStimulus(1'b1, 4'b0100); checkAll("rel1", 2, 1, 0, 0, 0, 1);
        applyStimulus(1'b1, 4'b0010); checkAll("rel2", 1, 1, 1, 0, 0, 1);

        // Two bits set, then no bits set.
        applyStimulus(1'b1, 4'b0110); checkAll("twobit", 1, 0, 0, 1, 0, 2);
        applyStimulus(1'b1, 4'b0000); checkAll("zero", 1, 0, 0, 0, 0, 2);

        // Relock, then en=0 with garbage for five cycles.
        applyStimulus(1'b1, 4'b1000);
        applyStimulus(1'b1, 4'b0100); checkAll("rel3", 2, 1, 0, 0, 0, 2);
        applyStimulus(1'b1, 4'b0010); checkAll("rel4", 1, 1, 1, 0, 0, 2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, (i % 2 == 0) ? 4'b1111 : 4'b0101);
            checkAll("enlow", 1, 1, 1, 0, 0, 2);
        end

        // Stalled counter: same code twice while locked.
        applyStimulus(1'b1, 4'b0010); checkAll("stall", 1, 1, 0, 1, 0, 3);

        // Lock/stall loop to drive err_cnt into saturation.
        cur = 1;
        for (int k = 0; k < 260; k++) begin
            s1 = (cur + WIDTH - 1) % WIDTH;
            s2 = (s1 + WIDTH - 1) % WIDTH;
            applyStimulus(1'b1, 4'b0001 << s1);
            applyStimulus(1'b1, 4'b0001 << s2);
            applyStimulus(1'b1, 4'b0001 << s2);
            cur = s2;
        end
        checkAll("sat", cur, 1, 0, 1, 0, 255);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("asyncrst", 0, 0, 0, 0, 0, 0);

        // First edge after release samples normally; relock needs full LOCK_N.
        en      = 1'b1;
        ring_in = 4'b0100;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll("post1", 2, 1, 0, 0, 0, 0);
        applyStimulus(1'b1, 4'b0010); checkAll("post2", 1, 1, 0, 0, 0, 0);
        applyStimulus(1'b1, 4'b0001); checkAll("post3", 0, 1, 1, 0, 0, 0);
        applyStimulus(1'b1, 4'b1000); checkAll("post4", 3, 1, 1, 0, 1, 0);
        applyStimulus(1'b0, 4'b0000);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
